// File: rtl/clock_ctrl_if.sv
// Signal bundle between the button/counter side and the clock_ctrl sequencer.
// slave is the controller view, master is the view of the blocks around it.
interface clock_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_stop;
  logic       btn_snooze;
  logic [7:0] hh_in;
  logic [7:0] mm_in;
  logic [7:0] ss_in;
  logic       pm_in;
  logic       alarm_en;
  logic       al_we;
  logic [7:0] al_hh;
  logic [7:0] al_mm;
  logic       al_pm;
  logic       tick;
  logic       load;
  logic [7:0] ld_hh;
  logic [7:0] ld_mm;
  logic       ld_pm;
  logic [1:0] mode;
  logic       buzzer;
  logic       snoozing;

  modport master (
    output btn_mode, btn_inc, btn_stop, btn_snooze,
    output hh_in, mm_in, ss_in, pm_in,
    output alarm_en, al_we, al_hh, al_mm, al_pm,
    input  tick, load, ld_hh, ld_mm, ld_pm, mode, buzzer, snoozing
  );

  modport slave (
    input  btn_mode, btn_inc, btn_stop, btn_snooze,
    input  hh_in, mm_in, ss_in, pm_in,
    input  alarm_en, al_we, al_hh, al_mm, al_pm,
    output tick, load, ld_hh, ld_mm, ld_pm, mode, buzzer, snoozing
  );
endinterface

// File: rtl/clock_ctrl.sv
// Sequencer for a 12-hour hh:mm:ss counter: 1 Hz tick prescaler, time-set FSM with
// shadow edit and one-cycle parallel load, and alarm ring/snooze FSM. All outputs registered.
module clock_ctrl #(
  parameter int unsigned TICK_DIV    = 4,
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300
) (
  input logic         clk,
  input logic         reset,
  clock_ctrl_if.slave io_bus
);

  localparam int unsigned PreW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CntMax = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [PreW-1:0] PreLast    = PreW'(TICK_DIV - 1);
  localparam logic [CntW-1:0] RingLast   = CntW'(RING_SECS - 1);
  localparam logic [CntW-1:0] SnoozeLast = CntW'(SNOOZE_SECS - 1);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StSetHh  = 2'd1,
    StSetMm  = 2'd2,
    StCommit = 2'd3
  } set_st_e;

  typedef enum logic [1:0] {
    StAlIdle   = 2'd0,
    StAlRing   = 2'd1,
    StAlSnooze = 2'd2
  } al_st_e;

  set_st_e         r_mode;
  logic [PreW-1:0] r_pre;
  logic            r_tick;
  logic            r_load;
  logic [7:0]      r_sh_hh;
  logic [7:0]      r_sh_mm;
  logic            r_sh_pm;

  logic [7:0]      r_al_hh;
  logic [7:0]      r_al_mm;
  logic            r_al_pm;

  al_st_e          r_al_st;
  logic [CntW-1:0] r_cnt;
  logic            r_match;
  logic            r_buzzer;
  logic            r_snoozing;

  logic [7:0]      w_hh_inc;
  logic            w_pm_inc;
  logic [7:0]      w_mm_inc;
  logic            w_al_wr_ok;
  logic            w_match;
  logic            w_trigger;

  // Hour wheel 12 -> 1 -> ... -> 11 -> 12; AM/PM flips entering 12.
  always_comb begin
    w_hh_inc = r_sh_hh + 8'd1;
    w_pm_inc = r_sh_pm;
    if (r_sh_hh >= 8'd12) begin
      w_hh_inc = 8'd1;
    end else if (r_sh_hh == 8'd11) begin
      w_hh_inc = 8'd12;
      w_pm_inc = ~r_sh_pm;
    end
  end

  assign w_mm_inc = (r_sh_mm >= 8'd59) ? 8'd0 : r_sh_mm + 8'd1;

  // Prescaler and time-set FSM. Leaving RUN clears the prescaler so the first tick back
  // in RUN lands a full TICK_DIV cycles later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode  <= StRun;
      r_pre   <= '0;
      r_tick  <= 1'b0;
      r_load  <= 1'b0;
      r_sh_hh <= 8'd12;
      r_sh_mm <= 8'd0;
      r_sh_pm <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_load <= 1'b0;
      unique case (r_mode)
        StRun: begin
          if (io_bus.btn_mode) begin
            r_mode  <= StSetHh;
            r_pre   <= '0;
            r_sh_hh <= io_bus.hh_in;
            r_sh_mm <= io_bus.mm_in;
            r_sh_pm <= io_bus.pm_in;
          end else if (r_pre == PreLast) begin
            r_pre  <= '0;
            r_tick <= 1'b1;
          end else begin
            r_pre <= r_pre + 1'b1;
          end
        end
        StSetHh: begin
          if (io_bus.btn_mode) begin
            r_mode <= StSetMm;
          end else if (io_bus.btn_inc) begin
            r_sh_hh <= w_hh_inc;
            r_sh_pm <= w_pm_inc;
          end
        end
        StSetMm: begin
          if (io_bus.btn_mode) begin
            r_mode <= StCommit;
            r_load <= 1'b1;
          end else if (io_bus.btn_inc) begin
            r_sh_mm <= w_mm_inc;
          end
        end
        StCommit: r_mode <= StRun;
        default:  r_mode <= StRun;
      endcase
    end
  end

  assign w_al_wr_ok = io_bus.al_we && (io_bus.al_hh != 8'd0) && (io_bus.al_hh <= 8'd12) &&
                      (io_bus.al_mm <= 8'd59);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_al_hh <= 8'd12;
      r_al_mm <= 8'd0;
      r_al_pm <= 1'b0;
    end else if (w_al_wr_ok) begin
      r_al_hh <= io_bus.al_hh;
      r_al_mm <= io_bus.al_mm;
      r_al_pm <= io_bus.al_pm;
    end
  end

  assign w_match = io_bus.alarm_en && (r_mode == StRun) && (io_bus.hh_in == r_al_hh) &&
                   (io_bus.mm_in == r_al_mm) && (io_bus.ss_in == 8'd0) &&
                   (io_bus.pm_in == r_al_pm);
  assign w_trigger = w_match && !r_match;

  // Alarm FSM; ring/snooze durations are counted in ticks, so they freeze while setting time.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_al_st    <= StAlIdle;
      r_cnt      <= '0;
      r_match    <= 1'b0;
      r_buzzer   <= 1'b0;
      r_snoozing <= 1'b0;
    end else begin
      r_match <= w_match;
      if (!io_bus.alarm_en) begin
        r_al_st    <= StAlIdle;
        r_cnt      <= '0;
        r_buzzer   <= 1'b0;
        r_snoozing <= 1'b0;
      end else begin
        unique case (r_al_st)
          StAlIdle: begin
            if (w_trigger) begin
              r_al_st  <= StAlRing;
              r_cnt    <= '0;
              r_buzzer <= 1'b1;
            end
          end
          StAlRing: begin
            if (io_bus.btn_stop) begin
              r_al_st  <= StAlIdle;
              r_buzzer <= 1'b0;
            end else if (io_bus.btn_snooze) begin
              r_al_st    <= StAlSnooze;
              r_cnt      <= '0;
              r_buzzer   <= 1'b0;
              r_snoozing <= 1'b1;
            end else if (r_tick) begin
              if (r_cnt == RingLast) begin
                r_al_st  <= StAlIdle;
                r_cnt    <= '0;
                r_buzzer <= 1'b0;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          StAlSnooze: begin
            if (io_bus.btn_stop) begin
              r_al_st    <= StAlIdle;
              r_snoozing <= 1'b0;
            end else if (r_tick) begin
              if (r_cnt == SnoozeLast) begin
                r_al_st    <= StAlRing;
                r_cnt      <= '0;
                r_buzzer   <= 1'b1;
                r_snoozing <= 1'b0;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          default: begin
            r_al_st    <= StAlIdle;
            r_buzzer   <= 1'b0;
            r_snoozing <= 1'b0;
          end
        endcase
      end
    end
  end

  assign io_bus.tick     = r_tick;
  assign io_bus.load     = r_load;
  assign io_bus.ld_hh    = r_sh_hh;
  assign io_bus.ld_mm    = r_sh_mm;
  assign io_bus.ld_pm    = r_sh_pm;
  assign io_bus.mode     = r_mode;
  assign io_bus.buzzer   = r_buzzer;
  assign io_bus.snoozing = r_snoozing;

endmodule

// File: tb/tb_clock_ctrl.sv
// Scoreboard bench for clock_ctrl: stimulus queues expected outputs per clock edge,
// a negedge monitor pops and compares them.
module tb_clock_ctrl;

  localparam int TickDiv    = 4;
  localparam int RingSecs   = 60;
  localparam int SnoozeSecs = 300;

  localparam int SelTick   = 0;
  localparam int SelLoad   = 1;
  localparam int SelMode   = 2;
  localparam int SelBuzzer = 3;
  localparam int SelSnooze = 4;
  localparam int SelLdHh   = 5;
  localparam int SelLdMm   = 6;
  localparam int SelLdPm   = 7;

  typedef struct packed {
    int         cyc;
    int         sel;
    logic [7:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   run_start = 0;
  exp_t sb[$];

  clock_ctrl_if bus();

  clock_ctrl #(
    .TICK_DIV   (TickDiv),
    .RING_SECS  (RingSecs),
    .SNOOZE_SECS(SnoozeSecs)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      SelTick:   return {7'd0, bus.tick};
      SelLoad:   return {7'd0, bus.load};
      SelMode:   return {6'd0, bus.mode};
      SelBuzzer: return {7'd0, bus.buzzer};
      SelSnooze: return {7'd0, bus.snoozing};
      SelLdHh:   return bus.ld_hh;
      SelLdMm:   return bus.ld_mm;
      SelLdPm:   return {7'd0, bus.ld_pm};
      default:   return 8'hff;
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      SelTick:   return "tick";
      SelLoad:   return "load";
      SelMode:   return "mode";
      SelBuzzer: return "buzzer";
      SelSnooze: return "snoozing";
      SelLdHh:   return "ld_hh";
      SelLdMm:   return "ld_mm";
      SelLdPm:   return "ld_pm";
      default:   return "unknown";
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s @edge %0d: not sampled in time (now edge %0d), required %0d",
                 sel_name(e.sel), e.cyc, cyc, e.val);
      end else if (observe(e.sel) !== e.val) begin
        errors++;
        $display("FAIL %s @edge %0d: got %0d, required %0d",
                 sel_name(e.sel), e.cyc, observe(e.sel), e.val);
      end
    end
  end

  // Expect a value right after the next rising edge.
  task automatic expect_nx(input int sel, input logic [7:0] val);
    exp_t e;
    e.cyc = cyc + 1;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic m, input logic i, input logic sn, input logic st);
    bus.btn_mode   = m;
    bus.btn_inc    = i;
    bus.btn_snooze = sn;
    bus.btn_stop   = st;
    step();
    bus.btn_mode   = 1'b0;
    bus.btn_inc    = 1'b0;
    bus.btn_snooze = 1'b0;
    bus.btn_stop   = 1'b0;
  endtask

  task automatic set_time(input int hh, input int mm, input int ss, input logic pm);
    bus.hh_in = 8'(hh);
    bus.mm_in = 8'(mm);
    bus.ss_in = 8'(ss);
    bus.pm_in = pm;
  endtask

  // True if tick is high right after edge e, given RUN started at edge run_start.
  function automatic bit is_tick_edge(input int e);
    return (e > run_start) && (((e - run_start) % TickDiv) == 0);
  endfunction

  function automatic int nth_tick_edge(input int from, input int n);
    int k = 0;
    for (int e = from; e < from + 100000; e++) begin
      if (is_tick_edge(e)) begin
        k++;
        if (k == n) return e;
      end
    end
    return -1;
  endfunction

  int t_trig;
  int t_end;

  initial begin
    reset          = 1'b1;
    bus.btn_mode   = 1'b0;
    bus.btn_inc    = 1'b0;
    bus.btn_stop   = 1'b0;
    bus.btn_snooze = 1'b0;
    bus.alarm_en   = 1'b0;
    bus.al_we      = 1'b0;
    bus.al_hh      = 8'd0;
    bus.al_mm      = 8'd0;
    bus.al_pm      = 1'b0;
    set_time(12, 0, 0, 1'b0);

    // Reset held for two edges, then tick every fourth edge.
    step();
    expect_nx(SelMode, 0);
    expect_nx(SelTick, 0);
    expect_nx(SelLoad, 0);
    expect_nx(SelBuzzer, 0);
    expect_nx(SelSnooze, 0);
    expect_nx(SelLdHh, 12);
    expect_nx(SelLdMm, 0);
    expect_nx(SelLdPm, 0);
    step();
    reset = 1'b0;
    run_start = cyc;
    for (int k = 1; k <= 13; k++) begin
      expect_nx(SelTick, ((k % 4) == 0) ? 8'd1 : 8'd0);
      expect_nx(SelLoad, 0);
      step();
    end

    // 3:15 PM -> two hour incs, 50 minute incs -> 5:05 PM
    set_time(3, 15, 0, 1'b1);
    expect_nx(SelMode, 1);
    expect_nx(SelTick, 0);
    expect_nx(SelLdHh, 3);
    expect_nx(SelLdMm, 15);
    expect_nx(SelLdPm, 1);
    press(1, 0, 0, 0);
    expect_nx(SelLdHh, 4);
    expect_nx(SelTick, 0);
    press(0, 1, 0, 0);
    expect_nx(SelLdHh, 5);
    press(0, 1, 0, 0);
    expect_nx(SelMode, 2);
    press(1, 0, 0, 0);
    for (int i = 0; i < 50; i++) begin
      expect_nx(SelTick, 0);
      if (i == 43) expect_nx(SelLdMm, 59);
      if (i == 44) expect_nx(SelLdMm, 0);
      press(0, 1, 0, 0);
    end
    expect_nx(SelMode, 3);
    expect_nx(SelLoad, 1);
    expect_nx(SelTick, 0);
    expect_nx(SelLdHh, 5);
    expect_nx(SelLdMm, 5);
    expect_nx(SelLdPm, 1);
    press(1, 0, 0, 0);
    expect_nx(SelMode, 0);
    expect_nx(SelLoad, 0);
    expect_nx(SelTick, 0);
    step();
    run_start = cyc;
    for (int k = 1; k <= 4; k++) begin
      expect_nx(SelTick, (k == 4) ? 8'd1 : 8'd0);
      step();
    end

    // 11 AM -> 12 PM -> 1 PM, then mode+inc together
    set_time(11, 0, 0, 1'b0);
    expect_nx(SelMode, 1);
    expect_nx(SelLdHh, 11);
    expect_nx(SelLdPm, 0);
    press(1, 0, 0, 0);
    expect_nx(SelLdHh, 12);
    expect_nx(SelLdPm, 1);
    press(0, 1, 0, 0);
    expect_nx(SelLdHh, 1);
    expect_nx(SelLdPm, 1);
    press(0, 1, 0, 0);
    expect_nx(SelMode, 2);
    expect_nx(SelLdHh, 1);
    expect_nx(SelLdMm, 0);
    press(1, 1, 0, 0);
    expect_nx(SelMode, 3);
    expect_nx(SelLoad, 1);
    expect_nx(SelLdHh, 1);
    expect_nx(SelLdPm, 1);
    press(1, 0, 0, 0);
    expect_nx(SelMode, 0);
    expect_nx(SelLoad, 0);
    step();
    run_start = cyc;

    // Alarm 7:30 AM rings for 60 ticks
    bus.al_hh    = 8'd7;
    bus.al_mm    = 8'd30;
    bus.al_pm    = 1'b0;
    bus.al_we    = 1'b1;
    bus.alarm_en = 1'b1;
    expect_nx(SelBuzzer, 0);
    step();
    bus.al_we = 1'b0;
    set_time(7, 30, 0, 1'b0);
    t_trig = cyc + 1;
    expect_nx(SelBuzzer, 1);
    expect_nx(SelSnooze, 0);
    step();
    set_time(7, 30, 1, 1'b0);
    t_end = nth_tick_edge(t_trig, RingSecs);
    while (cyc < t_end + 1) begin
      if (cyc + 1 == t_end) expect_nx(SelBuzzer, 1);
      if (cyc + 1 == t_end + 1) begin
        expect_nx(SelBuzzer, 0);
        expect_nx(SelSnooze, 0);
      end
      step();
    end

    // Re-trigger, snooze for 300 ticks, re-ring, stop
    set_time(7, 30, 0, 1'b0);
    expect_nx(SelBuzzer, 1);
    step();
    set_time(7, 30, 1, 1'b0);
    step();
    step();
    expect_nx(SelBuzzer, 0);
    expect_nx(SelSnooze, 1);
    press(0, 0, 1, 0);
    t_end = nth_tick_edge(cyc, SnoozeSecs);
    while (cyc < t_end + 1) begin
      if (cyc + 1 == t_end) begin
        expect_nx(SelSnooze, 1);
        expect_nx(SelBuzzer, 0);
      end
      if (cyc + 1 == t_end + 1) begin
        expect_nx(SelSnooze, 0);
        expect_nx(SelBuzzer, 1);
      end
      step();
    end
    expect_nx(SelBuzzer, 0);
    expect_nx(SelSnooze, 0);
    press(0, 0, 0, 1);

    // Invalid alarm write is dropped: 7:30 AM still fires
    bus.al_hh = 8'd13;
    bus.al_mm = 8'd0;
    bus.al_pm = 1'b1;
    bus.al_we = 1'b1;
    step();
    bus.al_we = 1'b0;
    set_time(7, 30, 0, 1'b0);
    expect_nx(SelBuzzer, 1);
    step();
    set_time(7, 30, 1, 1'b0);
    bus.alarm_en = 1'b0;
    expect_nx(SelBuzzer, 0);
    expect_nx(SelSnooze, 0);
    step();
    bus.alarm_en = 1'b1;

    // Stop and snooze together: stop wins
    set_time(7, 30, 0, 1'b0);
    expect_nx(SelBuzzer, 1);
    step();
    set_time(7, 30, 1, 1'b0);
    expect_nx(SelBuzzer, 0);
    expect_nx(SelSnooze, 0);
    press(0, 0, 1, 1);

    // Reset while in SET_MM, with btn_mode also asserted
    expect_nx(SelMode, 1);
    press(1, 0, 0, 0);
    expect_nx(SelMode, 2);
    press(1, 0, 0, 0);
    reset = 1'b1;
    bus.btn_mode = 1'b1;
    expect_nx(SelMode, 0);
    expect_nx(SelLoad, 0);
    expect_nx(SelBuzzer, 0);
    expect_nx(SelLdHh, 12);
    expect_nx(SelLdMm, 0);
    expect_nx(SelLdPm, 0);
    step();
    bus.btn_mode = 1'b0;
    reset = 1'b0;
    step();
    step();

    if (sb.size() != 0) begin
      $display("FAIL scoreboard: %0d expected values never compared, required 0", sb.size());
      errors += sb.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
